// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//   FPGA top-level reset sequencer. Two-flop synchronises every asynchronous
//   clock-generator lock indication, waits for all of them to stay high for
//   STABLE_CYCLES, then releases NUM_OUT active-low resets one at a time in
//   index order. Releases are spaced by at least STEP_CYCLES, and a stage can
//   optionally wait for its acknowledge. Any lock loss or software request
//   pulls every reset back low. A saturating counter records lock-caused aborts.
//
// Ports:
//   clk_core       in   1           sole clock, rising edge
//   reset_n        in   1           synchronous, active-low reset
//   lock_i         in   LOCK_WIDTH  asynchronous lock indications, 1=locked
//   soft_rst_req   in   1           synchronous request to re-run the sequence
//   stage_ack      in   NUM_OUT     per-stage acknowledge (used where ACK_MASK=1)
//   rst_n_o        out  NUM_OUT     sequenced active-low resets
//   ready          out  1           all stages released and final step elapsed
//   state_o        out  2           WAIT_LOCK=0, STABLE=1, RELEASE=2, RUN=3
//   lock_loss_cnt  out  8           saturating count of lock-caused aborts
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int                 NUM_OUT       = 3,
  parameter int                 LOCK_WIDTH    = 2,
  parameter int                 STABLE_CYCLES = 1024,
  parameter int                 STEP_CYCLES   = 16,
  parameter logic [NUM_OUT-1:0] ACK_MASK      = '0
) (
  input  logic                  clk_core,
  input  logic                  reset_n,
  input  logic [LOCK_WIDTH-1:0] lock_i,
  input  logic                  soft_rst_req,
  input  logic [NUM_OUT-1:0]    stage_ack,
  output logic [NUM_OUT-1:0]    rst_n_o,
  output logic                  ready,
  output logic [1:0]            state_o,
  output logic [7:0]            lock_loss_cnt
);

  localparam int STABLE_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int STEP_W   = (STEP_CYCLES > 1)   ? $clog2(STEP_CYCLES)   : 1;
  localparam int IDX_W    = (NUM_OUT > 1)       ? $clog2(NUM_OUT)       : 1;

  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
  localparam logic [STEP_W-1:0]   STEP_LAST   = STEP_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [LOCK_WIDTH-1:0] lock_p0;
  logic [LOCK_WIDTH-1:0] lock_p1;
  logic                  locked;

  state_t                state;
  state_t                state_nxt;
  logic [STABLE_W-1:0]   stable_cnt;
  logic [STABLE_W-1:0]   stable_cnt_nxt;
  logic [STEP_W-1:0]     step_cnt;
  logic [STEP_W-1:0]     step_cnt_nxt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic [NUM_OUT-1:0]    rst_n_nxt;
  logic                  ready_nxt;
  logic [7:0]            loss_cnt_nxt;
  logic                  abort;
  logic                  advance;

  // Synchroniser stage: lock_p0 is the metastability flop, lock_p1 is safe to use
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      lock_p0 <= '0;
      lock_p1 <= '0;
    end else begin
      lock_p0 <= lock_i;
      lock_p1 <= lock_p0;
    end
  end

  assign locked = &lock_p1;

  // Sequencing stage: next-state and next-output decode
  always_comb begin
    state_nxt      = state;
    stable_cnt_nxt = stable_cnt;
    step_cnt_nxt   = step_cnt;
    idx_nxt        = idx;
    rst_n_nxt      = rst_n_o;
    ready_nxt      = ready;
    loss_cnt_nxt   = lock_loss_cnt;
    advance        = 1'b0;

    // Abort wins over every other transition, including completions in the same cycle.
    abort = (state != WAIT_LOCK) && (!locked || soft_rst_req);

    if (abort) begin
      state_nxt      = WAIT_LOCK;
      stable_cnt_nxt = '0;
      step_cnt_nxt   = '0;
      idx_nxt        = '0;
      rst_n_nxt      = '0;
      ready_nxt      = 1'b0;
      // Only lock loss is counted; a simultaneous soft request still counts.
      if (!locked && (lock_loss_cnt != 8'hFF)) begin
        loss_cnt_nxt = lock_loss_cnt + 8'd1;
      end
    end else begin
      case (state)
        WAIT_LOCK: begin
          rst_n_nxt = '0;
          ready_nxt = 1'b0;
          if (locked) begin
            state_nxt      = STABLE;
            stable_cnt_nxt = '0;
          end
        end

        STABLE: begin
          if (stable_cnt == STABLE_LAST) begin
            state_nxt    = RELEASE;
            idx_nxt      = '0;
            step_cnt_nxt = '0;
            rst_n_nxt[0] = 1'b1;
          end else begin
            stable_cnt_nxt = stable_cnt + 1'b1;
          end
        end

        RELEASE: begin
          // Saturate so an ack-gated stage keeps its "step elapsed" condition.
          if (step_cnt != STEP_LAST) begin
            step_cnt_nxt = step_cnt + 1'b1;
          end
          advance = (step_cnt == STEP_LAST) && (!ACK_MASK[idx] || stage_ack[idx]);
          if (advance) begin
            if (idx == IDX_LAST) begin
              state_nxt = RUN;
              ready_nxt = 1'b1;
            end else begin
              idx_nxt      = idx + 1'b1;
              step_cnt_nxt = '0;
              for (int k = 0; k < NUM_OUT; k++) begin
                if (k == int'(idx_nxt)) begin
                  rst_n_nxt[k] = 1'b1;
                end
              end
            end
          end
        end

        RUN: begin
          rst_n_nxt = '1;
          ready_nxt = 1'b1;
        end

        default: begin
          state_nxt = WAIT_LOCK;
          rst_n_nxt = '0;
          ready_nxt = 1'b0;
        end
      endcase
    end
  end

  // Register stage: every output comes straight from a flop
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state         <= WAIT_LOCK;
      stable_cnt    <= '0;
      step_cnt      <= '0;
      idx           <= '0;
      rst_n_o       <= '0;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state         <= state_nxt;
      stable_cnt    <= stable_cnt_nxt;
      step_cnt      <= step_cnt_nxt;
      idx           <= idx_nxt;
      rst_n_o       <= rst_n_nxt;
      ready         <= ready_nxt;
      lock_loss_cnt <= loss_cnt_nxt;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Purpose:
//   Directed self-checking bench for reset_sequencer with NUM_OUT=3,
//   LOCK_WIDTH=2, STABLE_CYCLES=8, STEP_CYCLES=4, ACK_MASK=3'b010.
//   Edges are numbered from the first edge with reset_n=1.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int S = 8;   // STABLE_CYCLES
  localparam int P = 4;   // STEP_CYCLES

  logic       clk_core = 1'b0;
  logic       reset_n  = 1'b0;
  logic [1:0] lock_i   = 2'b11;
  logic       soft_rst_req = 1'b0;
  logic [2:0] stage_ack    = 3'b111;
  logic [2:0] rst_n_o;
  logic       ready;
  logic [1:0] state_o;
  logic [7:0] lock_loss_cnt;

  int total  = 0;
  int bad    = 0;
  int edge_n = 0;

  reset_sequencer #(
    .NUM_OUT       (3),
    .LOCK_WIDTH    (2),
    .STABLE_CYCLES (S),
    .STEP_CYCLES   (P),
    .ACK_MASK      (3'b010)
  ) dut (
    .clk_core      (clk_core),
    .reset_n       (reset_n),
    .lock_i        (lock_i),
    .soft_rst_req  (soft_rst_req),
    .stage_ack     (stage_ack),
    .rst_n_o       (rst_n_o),
    .ready         (ready),
    .state_o       (state_o),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk_core = ~clk_core;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got=%0d exp=%0d", tag, edge_n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_core);
    edge_n++;
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_rst"},   int'(rst_n_o), 0);
    check_val({tag, "_ready"}, int'(ready), 0);
    check_val({tag, "_state"}, int'(state_o), 0);
    check_val({tag, "_cnt"},   int'(lock_loss_cnt), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    check_reset_vals("reset");
    reset_n = 1'b1;
    edge_n  = 0;
  endtask

  // Step up to edge 'last', checking the undisturbed sequence whose STABLE
  // entry is edge 'base': releases at base+S, base+S+P, base+S+2P, ready at base+S+3P.
  task automatic seq_check(input int base, input int last);
    int rel;
    int exp_state;
    int exp_rst;
    while (edge_n < last) begin
      step();
      rel       = edge_n - base;
      exp_state = (rel < 0) ? 0 : (rel < S) ? 1 : (rel < S + 3*P) ? 2 : 3;
      exp_rst   = ((rel >= S) ? 1 : 0) | ((rel >= S + P) ? 2 : 0) | ((rel >= S + 2*P) ? 4 : 0);
      check_val("seq_state", int'(state_o), exp_state);
      check_val("seq_rst",   int'(rst_n_o), exp_rst);
      check_val("seq_ready", int'(ready), (rel >= S + 3*P) ? 1 : 0);
    end
  endtask

  initial begin
    // Nominal sequence: rst_n_o[0..2] at 11/15/19, ready at 23
    lock_i    = 2'b11;
    stage_ack = 3'b111;
    do_reset();
    seq_check(3, 24);
    check_val("nom_cnt", int'(lock_loss_cnt), 0);

    // Glitch on lock_i[1] sampled at edge 6: abort at 8, STABLE again at 9
    do_reset();
    seq_check(3, 5);
    lock_i = 2'b01;
    seq_check(3, 6);
    lock_i = 2'b11;
    seq_check(3, 7);
    step();
    check_val("glitch_state", int'(state_o), 0);
    check_val("glitch_rst",   int'(rst_n_o), 0);
    check_val("glitch_cnt",   int'(lock_loss_cnt), 1);
    seq_check(9, 24);
    check_val("glitch_cnt_end", int'(lock_loss_cnt), 1);

    // Ack gating on stage 1: ack rises after edge 40, rst_n_o[2] at 41, ready at 45
    stage_ack = 3'b000;
    do_reset();
    seq_check(3, 15);
    while (edge_n < 40) begin
      step();
      check_val("gate_rst",   int'(rst_n_o), 3);
      check_val("gate_state", int'(state_o), 2);
      check_val("gate_ready", int'(ready), 0);
    end
    stage_ack = 3'b010;
    step();
    check_val("gate_rst2", int'(rst_n_o), 7);
    while (edge_n < 44) step();
    check_val("gate_ready44", int'(ready), 0);
    step();
    check_val("gate_ready45", int'(ready), 1);
    check_val("gate_run",     int'(state_o), 3);

    // Abort in RUN: lock_i[0] low sampled at edge 50, resets drop after 52
    while (edge_n < 49) step();
    lock_i = 2'b10;
    step();
    step();
    check_val("run_rst51",   int'(rst_n_o), 7);
    check_val("run_ready51", int'(ready), 1);
    step();
    check_val("run_rst52",   int'(rst_n_o), 0);
    check_val("run_ready52", int'(ready), 0);
    check_val("run_state52", int'(state_o), 0);
    check_val("run_cnt52",   int'(lock_loss_cnt), 1);
    lock_i = 2'b11;
    seq_check(55, 76);
    check_val("run_cnt_end", int'(lock_loss_cnt), 1);

    // Soft request on the STABLE->RELEASE completion edge (11)
    stage_ack = 3'b111;
    do_reset();
    seq_check(3, 10);
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    check_val("soft_state", int'(state_o), 0);
    check_val("soft_rst",   int'(rst_n_o), 0);
    check_val("soft_cnt",   int'(lock_loss_cnt), 0);
    seq_check(12, 20);
    check_val("soft_cnt_end", int'(lock_loss_cnt), 0);

    // Saturation: 300 lock-loss aborts from STABLE, then reset mid-RELEASE
    do_reset();
    seq_check(3, 5);
    for (int i = 0; i < 300; i++) begin
      lock_i = 2'b00;
      step();
      lock_i = 2'b11;
      step();
      step();
      step();
      if (i == 253) check_val("sat_cnt254", int'(lock_loss_cnt), 254);
    end
    check_val("sat_cnt",   int'(lock_loss_cnt), 255);
    check_val("sat_state", int'(state_o), 1);
    for (int i = 0; i < 10; i++) step();
    check_val("mid_state", int'(state_o), 2);
    check_val("mid_rst",   int'(rst_n_o), 1);
    reset_n = 1'b0;
    step();
    check_reset_vals("mid_reset");
    reset_n = 1'b1;
    step();
    check_val("post_reset_state", int'(state_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
